// File: rtl/event_handle_router.sv
// Event handle table with immediate/delayed triggers driving one-hot event fire pulses.
// Define EVENT_HANDLE_ROUTER_STATS_EN to add the fire_count / null_err_count outputs.
module event_handle_router #(
    parameter int unsigned N = 4,
    localparam int unsigned HW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [HW-1:0] cmd_dst,
    input  logic [HW-1:0] cmd_src,
    output logic [N-1:0]  evt_fire,
    output logic [N-1:0]  evt_triggered,
    output logic [N-1:0]  handle_null,
`ifdef EVENT_HANDLE_ROUTER_STATS_EN
    output logic [15:0]   fire_count,
    output logic [7:0]    null_err_count,
`endif
    output logic          err_null
);

    typedef enum logic [0:0] {StInit, StRun} state_e;

    localparam logic [2:0] OpTrig    = 3'd1;
    localparam logic [2:0] OpTrigNb  = 3'd2;
    localparam logic [2:0] OpCopy    = 3'd3;
    localparam logic [2:0] OpSetNull = 3'd4;
    localparam logic [2:0] OpRebind  = 3'd5;
    localparam logic [2:0] OpClear   = 3'd6;

    state_e        state_q;
    logic [HW-1:0] init_cnt_q;
    logic [N-1:0]  null_q;
    logic [HW-1:0] ptr_q [N];
    logic [N-1:0]  pending_q;
    logic [N-1:0]  evt_fire_q;
    logic [N-1:0]  evt_fire_prev_q;
    logic          err_null_q;

    logic          accept;
    logic          dst_ok;
    logic          src_ok;
    logic [N-1:0]  imm_mask;
    logic [N-1:0]  nb_mask;
    logic          err_d;

    assign cmd_ready     = (state_q == StRun);
    assign accept        = cmd_valid & cmd_ready;
    assign dst_ok        = 32'(cmd_dst) < N;
    assign src_ok        = 32'(cmd_src) < N;
    assign evt_fire      = evt_fire_q;
    assign evt_triggered = evt_fire_q | evt_fire_prev_q;
    assign handle_null   = null_q;
    assign err_null      = err_null_q;

    // Triggers resolve through the table as it stands before this cycle's write.
    always_comb begin
        imm_mask = '0;
        nb_mask  = '0;
        err_d    = 1'b0;
        if (accept && dst_ok && (cmd_op == OpTrig || cmd_op == OpTrigNb)) begin
            if (null_q[cmd_dst]) begin
                err_d = 1'b1;
            end else if (cmd_op == OpTrig) begin
                imm_mask[ptr_q[cmd_dst]] = 1'b1;
            end else begin
                nb_mask[ptr_q[cmd_dst]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StInit;
            init_cnt_q      <= '0;
            null_q          <= '0;
            pending_q       <= '0;
            evt_fire_q      <= '0;
            evt_fire_prev_q <= '0;
            err_null_q      <= 1'b0;
            for (int i = 0; i < N; i++) begin
                ptr_q[i] <= '0;
            end
        end else begin
            evt_fire_q      <= imm_mask | pending_q;
            evt_fire_prev_q <= evt_fire_q;
            err_null_q      <= err_d;
            pending_q       <= nb_mask;
            case (state_q)
                StInit: begin
                    null_q[init_cnt_q] <= 1'b0;
                    ptr_q[init_cnt_q]  <= init_cnt_q;
                    pending_q          <= '0;
                    if (32'(init_cnt_q) == N - 1) begin
                        state_q    <= StRun;
                        init_cnt_q <= '0;
                    end else begin
                        init_cnt_q <= init_cnt_q + HW'(1);
                    end
                end
                StRun: begin
                    if (accept && dst_ok) begin
                        case (cmd_op)
                            OpCopy: begin
                                if (src_ok) begin
                                    null_q[cmd_dst] <= null_q[cmd_src];
                                    ptr_q[cmd_dst]  <= ptr_q[cmd_src];
                                end
                            end
                            OpSetNull: null_q[cmd_dst] <= 1'b1;
                            OpRebind: begin
                                null_q[cmd_dst] <= 1'b0;
                                ptr_q[cmd_dst]  <= cmd_dst;
                            end
                            OpClear: begin
                                state_q    <= StInit;
                                init_cnt_q <= '0;
                                pending_q  <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
                default: state_q <= StInit;
            endcase
        end
    end

`ifdef EVENT_HANDLE_ROUTER_STATS_EN
    logic [15:0] fire_count_q;
    logic [7:0]  null_err_count_q;
    logic [16:0] fire_pop;
    logic [16:0] fire_sum;
    logic        stats_clear;

    assign stats_clear    = accept && cmd_op == OpClear;
    assign fire_count     = fire_count_q;
    assign null_err_count = null_err_count_q;

    always_comb begin
        fire_pop = '0;
        for (int i = 0; i < N; i++) begin
            fire_pop = fire_pop + 17'(evt_fire_q[i]);
        end
        fire_sum = 17'(fire_count_q) + fire_pop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fire_count_q     <= '0;
            null_err_count_q <= '0;
        end else if (stats_clear) begin
            fire_count_q     <= '0;
            null_err_count_q <= '0;
        end else begin
            fire_count_q <= fire_sum[16] ? 16'hFFFF : fire_sum[15:0];
            if (err_null_q && null_err_count_q != 8'hFF) begin
                null_err_count_q <= null_err_count_q + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_event_handle_router.sv
// Self-checking bench: schedule-based reference model compared every cycle, plus directed
// literal checks of the trigger/copy/null/clear/reset scenarios.
module tb_event_handle_router;

    localparam int unsigned N  = 4;
    localparam int unsigned HW = $clog2(N);
    localparam int SZ = 1024;

    localparam logic [2:0] NOP = 3'd0, TRIG = 3'd1, TRIGNB = 3'd2, COPY = 3'd3;
    localparam logic [2:0] SETNULL = 3'd4, REBIND = 3'd5, CLEAR = 3'd6, RSVD = 3'd7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_op = '0;
    logic [HW-1:0] cmd_dst = '0;
    logic [HW-1:0] cmd_src = '0;
    logic [N-1:0]  evt_fire;
    logic [N-1:0]  evt_triggered;
    logic [N-1:0]  handle_null;
    logic          err_null;
`ifdef EVENT_HANDLE_ROUTER_STATS_EN
    logic [15:0]   fire_count;
    logic [7:0]    null_err_count;
`endif

    event_handle_router #(.N(N)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_dst       (cmd_dst),
        .cmd_src       (cmd_src),
        .evt_fire      (evt_fire),
        .evt_triggered (evt_triggered),
        .handle_null   (handle_null),
`ifdef EVENT_HANDLE_ROUTER_STATS_EN
        .fire_count    (fire_count),
        .null_err_count(null_err_count),
`endif
        .err_null      (err_null)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: handle table plus per-cycle schedules of expected fires and errors.
    bit [N-1:0] fire_sched [SZ];
    bit         err_sched  [SZ];
    int         m_ev [N];
    bit [N-1:0] m_null;
    int         init_left = N;
    bit         m_ready = 1'b0;
    int         cyc = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SZ; i++) begin
                fire_sched[i] = '0;
                err_sched[i]  = 1'b0;
            end
            for (int h = 0; h < N; h++) m_ev[h] = 0;
            m_null    = '0;
            init_left = N;
            m_ready   = 1'b0;
        end else begin
            if (m_ready) begin
                if (cmd_valid && cyc + 2 < SZ) begin
                    int d, s;
                    d = int'(cmd_dst);
                    s = int'(cmd_src);
                    case (cmd_op)
                        TRIG, TRIGNB: begin
                            if (m_null[d]) err_sched[cyc+1] = 1'b1;
                            else if (cmd_op == TRIG) fire_sched[cyc+1][m_ev[d]] = 1'b1;
                            else fire_sched[cyc+2][m_ev[d]] = 1'b1;
                        end
                        COPY: begin
                            m_ev[d]   = m_ev[s];
                            m_null[d] = m_null[s];
                        end
                        SETNULL: m_null[d] = 1'b1;
                        REBIND: begin
                            m_ev[d]   = d;
                            m_null[d] = 1'b0;
                        end
                        CLEAR: begin
                            init_left = N;
                            m_ready   = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end else if (init_left > 0) begin
                m_ev[N-init_left]   = N - init_left;
                m_null[N-init_left] = 1'b0;
                init_left--;
                if (init_left == 0) m_ready = 1'b1;
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        bit [N-1:0] exp_f, exp_t;
        exp_f = (cyc < SZ) ? fire_sched[cyc] : '0;
        exp_t = exp_f | ((cyc > 0 && cyc < SZ) ? fire_sched[cyc-1] : '0);
        chk("model cmd_ready", 32'(cmd_ready), 32'(m_ready));
        chk("model evt_fire", 32'(evt_fire), 32'(exp_f));
        chk("model evt_triggered", 32'(evt_triggered), 32'(exp_t));
        chk("model err_null", 32'(err_null), (cyc < SZ) ? 32'(err_sched[cyc]) : 0);
        chk("model handle_null", 32'(handle_null), 32'(m_null));
    end

    task automatic send(input logic [2:0] op, input int d, input int s);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_dst   = d[HW-1:0];
        cmd_src   = s[HW-1:0];
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = NOP;
    endtask

    // Counts cycles with cmd_ready low (bounded) and expects exactly N with no fires.
    task automatic count_init(input string name);
        int n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_ready) break;
            n++;
            chk({name, " fire during init"}, 32'(evt_fire), 0);
        end
        chk({name, " init length"}, n, N);
    endtask

    task automatic expect_fire(input string name, input logic [N-1:0] f);
        @(negedge clk);
        chk(name, 32'(evt_fire), 32'(f));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        count_init("reset");
        chk("reset handle_null", 32'(handle_null), 0);
`ifdef EVENT_HANDLE_ROUTER_STATS_EN
        chk("reset fire_count", 32'(fire_count), 0);
`endif

        send(TRIG, 1, 0);
        @(negedge clk);
        chk("trig fire T+1", 32'(evt_fire), 32'h2);
        chk("trig triggered T+1", 32'(evt_triggered), 32'h2);
        @(negedge clk);
        chk("trig fire T+2", 32'(evt_fire), 0);
        chk("trig triggered T+2", 32'(evt_triggered), 32'h2);
        @(negedge clk);
        chk("trig triggered T+3", 32'(evt_triggered), 0);

        send(COPY, 3, 2);
        send(COPY, 2, 1);
        send(TRIGNB, 2, 0);
        expect_fire("nb fire T+1", 4'b0000);
        expect_fire("nb fire T+2", 4'b0010);
        send(TRIG, 3, 0);
        expect_fire("copied h3 fire", 4'b0100);
        send(TRIG, 1, 0);
        expect_fire("h1 fire only", 4'b0010);

        send(SETNULL, 2, 0);
        @(negedge clk);
        chk("setnull handle_null", 32'(handle_null), 32'h4);
        send(TRIG, 2, 0);
        @(negedge clk);
        chk("null trig err", 32'(err_null), 1);
        chk("null trig no fire", 32'(evt_fire), 0);
        @(negedge clk);
        chk("null err one pulse", 32'(err_null), 0);

        send(TRIGNB, 0, 0);
        send(TRIG, 0, 0);
        @(negedge clk);
        chk("merged fire", 32'(evt_fire), 32'h1);
        chk("merged no err", 32'(err_null), 0);
        expect_fire("merged single pulse", 4'b0000);

        send(REBIND, 2, 0);
        @(negedge clk);
        chk("rebind handle_null", 32'(handle_null), 0);
        send(TRIG, 2, 0);
        expect_fire("rebind fire", 4'b0100);
        send(RSVD, 1, 0);
        expect_fire("reserved op", 4'b0000);

        send(SETNULL, 1, 0);
        send(COPY, 0, 1);
        @(negedge clk);
        chk("copy null bit", 32'(handle_null), 32'h3);
        send(TRIGNB, 0, 0);
        @(negedge clk);
        chk("nb null err", 32'(err_null), 1);

        send(CLEAR, 0, 0);
        count_init("clear");
        chk("clear handle_null", 32'(handle_null), 0);
        send(TRIG, 3, 0);
        expect_fire("clear identity h3", 4'b1000);

        send(TRIGNB, 1, 0);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("reset drops fire", 32'(evt_fire), 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        count_init("midreset");
`ifdef EVENT_HANDLE_ROUTER_STATS_EN
        chk("midreset fire_count", 32'(fire_count), 0);
        chk("midreset null_err_count", 32'(null_err_count), 0);
`endif
        chk("midreset handle_null", 32'(handle_null), 0);
        send(TRIG, 3, 0);
        expect_fire("midreset identity h3", 4'b1000);
        send(TRIG, 0, 0);
        expect_fire("midreset identity h0", 4'b0001);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
